pipeline_divider_stream_ctrl_module: RTL and testbench
======================================================

Name: pipeline_divider_stream_ctrl_module

Overview:
Handshake front/back end for the 8-bit pipelined signed divider; the divider core itself has no valid/ready and accepts one operand pair per clock.
- Accepts operand pairs on a valid/ready input port and drives the divider's dividend/divisor inputs.
- Tracks each issued operation through the divider latency with a tag shift register.
- Captures the matching quotient/reminder into an output FIFO presented on a valid/ready output port.
- Flags divide-by-zero and guarantees the FIFO never overflows, using credit-based issue.

Parameters:
LATENCY, 10, edges from the edge that updates div_dividend/div_divisor to the cycle the matching result is stable on div_quotient/div_reminder.
FIFO_DEPTH, 16, output FIFO entries; also the credit limit on operations in flight plus entries buffered.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept an operand pair
in_dividend  input  8  signed two's-complement dividend
in_divisor  input  8  signed two's-complement divisor
div_dividend  output  8  registered dividend to divider core
div_divisor  output  8  registered divisor to divider core
div_quotient  input  8  quotient from divider core
div_reminder  input  8  remainder from divider core
out_valid  output  1  result available at FIFO head
out_ready  input  1  consumer accepts result
out_quotient  output  8  signed quotient at FIFO head
out_reminder  output  8  signed remainder at FIFO head
out_div0  output  1  head entry was a divide-by-zero
busy  output  1  at least one operation in flight or buffered

Behaviour:
Interface:
- One clock (clk). Reset rst_n is asynchronous, active-low.

Reset (asynchronous, rst_n low):
- div_dividend = 0, div_divisor = 0.
- Tag shift register cleared; FIFO emptied; credit counter = 0.
- out_valid = 0, out_quotient = 0, out_reminder = 0, out_div0 = 0, busy = 0.
- in_ready = 1 only after rst_n is released.
- Reset mid-operation discards all in-flight and buffered results; nothing is emitted for them.

Issue:
- Accept happens when in_valid && in_ready at a rising edge.
- On accept, div_dividend/div_divisor load in_dividend/in_divisor.
- On accept, tag stage 0 loads {valid=1, div0=(in_divisor==0), dividend}.
- With no accept, div_* regs hold their value and tag stage 0 loads valid=0.

Credit:
- credit = in-flight tags + FIFO count, width clog2(FIFO_DEPTH+1).
- in_ready = (credit < FIFO_DEPTH). It is registered-state based and never depends combinationally on out_ready.
- Per edge: credit +1 on accept, -1 on pop, unchanged when both occur together.

Tag pipeline:
- LATENCY stages, shifting every edge.
- When stage LATENCY-1 holds valid=1, div_quotient/div_reminder belong to that tag. The result is written to the FIFO at the next edge.
- Divide-by-zero entries: quotient written as 8'h00, remainder as the carried dividend, div0 = 1. The core output is ignored for these entries.
- -128 / -1 passes the core result through unmodified (no overflow flag).

FIFO:
- First-word-fall-through: out_* show the head entry whenever out_valid = 1.
- Pop happens when out_valid && out_ready.
- Write and pop in the same cycle are both performed.
- Overflow is impossible by the credit rule. If an overflow ever occurred it is a design error, checked by an assertion in the bench.
- Order is strictly preserved.

Timing:
- Issue at edge 0 with the FIFO empty gives out_valid = 1 after edge LATENCY (10 cycles).
- Throughput is one result per cycle when out_ready is held high and FIFO_DEPTH >= LATENCY+1.

busy = (credit != 0).

Test Plan:
- 100 / 7, out_ready = 1 -> out_valid high exactly 10 cycles after accept; quotient 14, remainder 2, out_div0 = 0.
- -100 / 7 -> quotient 8'hF2 (-14), remainder 8'hFE (-2); 100 / -7 -> quotient 8'hF2, remainder 8'h02.
- 55 / 0 -> out_div0 = 1, quotient 8'h00, remainder 8'h37; the next op 9 / 3 -> quotient 3, remainder 0, out_div0 = 0.
- out_ready held low, in_valid held high with 20 distinct pairs -> exactly 16 accepted, then in_ready = 0. Release out_ready -> all 20 results emitted in order, none lost or duplicated, credit never exceeds 16.
- Back-to-back stream of 50 random pairs with out_ready = 1 -> one result per cycle after a 10-cycle fill; every result matches the reference model (truncating division, remainder takes the dividend's sign).
- rst_n pulsed low while 5 ops are in flight and 3 are buffered -> out_valid falls immediately, busy = 0; no stale result appears after release; a new op 20 / 6 returns quotient 3, remainder 2.

Source files
------------

// File: rtl/pipeline_divider_stream_ctrl_module.sv
// Valid/ready wrapper around a fixed-latency 8-bit signed divider core.
// Tags ride alongside the core; results land in a FWFT FIFO that credit-based issue keeps from overflowing.
module pipeline_divider_stream_ctrl_module #(
    parameter int LATENCY    = 10,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_dividend,
    input  logic [7:0] in_divisor,
    output logic [7:0] div_dividend,
    output logic [7:0] div_divisor,
    input  logic [7:0] div_quotient,
    input  logic [7:0] div_reminder,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_quotient,
    output logic [7:0] out_reminder,
    output logic       out_div0,
    output logic       busy
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef struct packed {
        logic       div0;
        logic [7:0] dvd;
    } tag_t;

    typedef struct packed {
        logic       div0;
        logic [7:0] quot;
        logic [7:0] rem;
    } result_t;

    logic [LATENCY-1:0] vld_pipe;
    tag_t               tag_pipe [LATENCY];
    result_t            mem [FIFO_DEPTH];
    result_t            wr_data;
    result_t            head;
    logic [CW-1:0]      credit;
    logic [CW-1:0]      fifo_count;
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic               accept;
    logic               push;
    logic               pop;

    // Credit covers tags in flight plus buffered entries, so every issued op has a FIFO slot.
    assign in_ready  = rst_n && (credit < CW'(FIFO_DEPTH));
    assign accept    = in_valid && in_ready;
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign push      = vld_pipe[LATENCY-1];
    assign busy      = (credit != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_dividend <= '0;
            div_divisor  <= '0;
        end else if (accept) begin
            div_dividend <= in_dividend;
            div_divisor  <= in_divisor;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            for (int i = 0; i < LATENCY; i++) tag_pipe[i] <= '0;
        end else begin
            vld_pipe[0]      <= accept;
            tag_pipe[0].div0 <= (in_divisor == 8'd0);
            tag_pipe[0].dvd  <= in_dividend;
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    // Divide-by-zero results come from the tag, never from the core.
    always_comb begin
        wr_data = '0;
        if (tag_pipe[LATENCY-1].div0) begin
            wr_data.div0 = 1'b1;
            wr_data.quot = 8'h00;
            wr_data.rem  = tag_pipe[LATENCY-1].dvd;
        end else begin
            wr_data.div0 = 1'b0;
            wr_data.quot = div_quotient;
            wr_data.rem  = div_reminder;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            credit     <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            case ({accept, pop})
                2'b10:   credit <= credit + CW'(1);
                2'b01:   credit <= credit - CW'(1);
                default: credit <= credit;
            endcase
        end
    end

    assign head         = mem[rd_ptr];
    assign out_quotient = out_valid ? head.quot : 8'h00;
    assign out_reminder = out_valid ? head.rem  : 8'h00;
    assign out_div0     = out_valid ? head.div0 : 1'b0;

endmodule

// File: tb/tb_pipeline_divider_stream_ctrl_module.sv
// Directed bench for the divider stream controller; includes a behavioural divider core of matching latency.
module tb_pipeline_divider_stream_ctrl_module;
    localparam int LATENCY    = 10;
    localparam int FIFO_DEPTH = 16;
    localparam int CORE_ST    = LATENCY - 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_dividend = '0;
    logic [7:0] in_divisor = '0;
    logic [7:0] div_dividend, div_divisor, div_quotient, div_reminder;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_quotient, out_reminder;
    logic       out_div0;
    logic       busy;
    logic [16:0] head;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_divider_stream_ctrl_module #(.LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dividend(in_dividend), .in_divisor(in_divisor),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_reminder(div_reminder),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_quotient(out_quotient), .out_reminder(out_reminder),
        .out_div0(out_div0), .busy(busy)
    );

    assign head = {out_div0, out_quotient, out_reminder};

    // Core model: garbage on divide-by-zero so the controller must ignore it.
    logic [7:0] cq [CORE_ST];
    logic [7:0] cr [CORE_ST];
    always @(posedge clk) begin
        int sa, sb;
        sa = int'($signed(div_dividend));
        sb = int'($signed(div_divisor));
        cq[0] <= (sb == 0) ? 8'hAA : 8'(sa / sb);
        cr[0] <= (sb == 0) ? 8'h55 : 8'(sa % sb);
        for (int i = 1; i < CORE_ST; i++) begin
            cq[i] <= cq[i-1];
            cr[i] <= cr[i-1];
        end
    end
    assign div_quotient = cq[CORE_ST-1];
    assign div_reminder = cr[CORE_ST-1];

    function automatic logic [16:0] exp_res(input logic [7:0] a, input logic [7:0] b);
        int sa, sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sb == 0) return {1'b1, 8'h00, a};
        return {1'b0, 8'(sa / sb), 8'(sa % sb)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
        n_cmp++;
        if ({out_valid, busy} !== 2'b00) begin n_err++; $display("FAIL reset_valid_busy got %b want 00", {out_valid, busy}); end
        n_cmp++;
        if (head !== 17'h0) begin n_err++; $display("FAIL reset_out got %h want 0", head); end
        n_cmp++;
        if ({div_dividend, div_divisor} !== 16'h0) begin n_err++; $display("FAIL reset_div_regs got %h want 0", {div_dividend, div_divisor}); end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready got %0b want 1", in_ready); end
        tick();
    endtask

    task automatic test_latency();
        int first;
        first = 0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_dividend = 8'd100; in_divisor = 8'd7;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if ({div_dividend, div_divisor} !== {8'd100, 8'd7}) begin n_err++; $display("FAIL lat_div_regs got %h want 6407", {div_dividend, div_divisor}); end
        for (int i = 1; i <= 15 && first == 0; i++) begin
            tick();
            if (out_valid) first = i;
        end
        n_cmp++;
        if (first !== 10) begin n_err++; $display("FAIL lat_cycles got %0d want 10", first); end
        n_cmp++;
        if (head !== {1'b0, 8'd14, 8'd2}) begin n_err++; $display("FAIL lat_100_7 got %h want %h", head, {1'b0, 8'd14, 8'd2}); end
        tick();
        n_cmp++;
        if ({out_valid, busy} !== 2'b00) begin n_err++; $display("FAIL lat_drain got %b want 00", {out_valid, busy}); end
    endtask

    task automatic test_pair(input string name, input logic [7:0] a0, input logic [7:0] b0, input logic [16:0] e0,
                             input logic [7:0] a1, input logic [7:0] b1, input logic [16:0] e1);
        int cyc;
        cyc = 0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_dividend = a0; in_divisor = b0;
        tick();
        in_dividend = a1; in_divisor = b1;
        tick();
        in_valid = 1'b0;
        while (!out_valid && cyc < 20) begin tick(); cyc++; end
        n_cmp++;
        if (head !== e0) begin n_err++; $display("FAIL %s_first got %h want %h", name, head, e0); end
        tick();
        n_cmp++;
        if (head !== e1 || out_valid !== 1'b1) begin n_err++; $display("FAIL %s_second got %b/%h want 1/%h", name, out_valid, head, e1); end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL %s_extra got %0b want 0", name, out_valid); end
    endtask

    task automatic test_signed();
        test_pair("signed", 8'h9C, 8'd7, {1'b0, 8'hF2, 8'hFE}, 8'd100, 8'hF9, {1'b0, 8'hF2, 8'h02});
    endtask

    task automatic test_div0();
        test_pair("div0", 8'd55, 8'd0, {1'b1, 8'h00, 8'h37}, 8'd9, 8'd3, {1'b0, 8'd3, 8'd0});
    endtask

    task automatic test_fill();
        logic [7:0] a [20];
        logic [7:0] b [20];
        int acc, pops, bad_order, over;
        logic fire, take;
        acc = 0; pops = 0; bad_order = 0; over = 0;
        for (int i = 0; i < 20; i++) begin
            a[i] = 8'(i * 6 + 7);
            b[i] = 8'((i % 4) + 2);
        end
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            in_dividend = a[acc]; in_divisor = b[acc];
            fire = in_ready;
            tick();
            if (fire) acc++;
        end
        n_cmp++;
        if (acc !== FIFO_DEPTH) begin n_err++; $display("FAIL fill_accepted got %0d want %0d", acc, FIFO_DEPTH); end
        n_cmp++;
        if ({in_ready, out_valid, busy} !== 3'b011) begin n_err++; $display("FAIL fill_full_flags got %b want 011", {in_ready, out_valid, busy}); end
        out_ready = 1'b1;
        for (int c = 0; c < 100 && pops < 20; c++) begin
            in_valid = (acc < 20);
            if (acc < 20) begin in_dividend = a[acc]; in_divisor = b[acc]; end
            fire = in_valid && in_ready;
            take = out_valid;
            if (take && head !== exp_res(a[pops], b[pops])) begin
                bad_order++;
                $display("FAIL fill_result_%0d got %h want %h", pops, head, exp_res(a[pops], b[pops]));
            end
            tick();
            if (fire) acc++;
            if (take) pops++;
            if (acc - pops > FIFO_DEPTH) over++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (bad_order != 0) begin n_err++; $display("FAIL fill_order got %0d bad want 0", bad_order); end
        n_cmp++;
        if (over != 0) begin n_err++; $display("FAIL fill_credit_over got %0d want 0", over); end
        n_cmp++;
        if (pops != 20 || acc != 20) begin n_err++; $display("FAIL fill_count got %0d/%0d want 20/20", acc, pops); end
        repeat (3) tick();
        n_cmp++;
        if ({out_valid, busy} !== 2'b00) begin n_err++; $display("FAIL fill_drain got %b want 00", {out_valid, busy}); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a [50];
        logic [7:0] b [50];
        int iss, got, first, gaps, stalls, bad;
        logic fire, take;
        iss = 0; got = 0; first = -1; gaps = 0; stalls = 0; bad = 0;
        for (int i = 0; i < 50; i++) begin
            a[i] = 8'($urandom_range(0, 255));
            b[i] = 8'($urandom_range(0, 255));
        end
        a[0] = 8'h80; b[0] = 8'hFF;
        a[1] = 8'h80; b[1] = 8'h01;
        a[2] = 8'h7F; b[2] = 8'h80;
        a[3] = 8'h81; b[3] = 8'h00;
        out_ready = 1'b1;
        for (int c = 0; c < 100 && got < 50; c++) begin
            in_valid = (iss < 50);
            if (iss < 50) begin
                in_dividend = a[iss]; in_divisor = b[iss];
                if (!in_ready) stalls++;
            end
            fire = in_valid && in_ready;
            take = out_valid;
            if (take) begin
                if (first < 0) first = c;
                if (head !== exp_res(a[got], b[got])) begin
                    bad++;
                    $display("FAIL b2b_result_%0d got %h want %h", got, head, exp_res(a[got], b[got]));
                end
            end else if (first >= 0) gaps++;
            tick();
            if (fire) iss++;
            if (take) got++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (first != 11) begin n_err++; $display("FAIL b2b_first got %0d want 11", first); end
        n_cmp++;
        if (bad != 0) begin n_err++; $display("FAIL b2b_values got %0d bad want 0", bad); end
        n_cmp++;
        if (gaps != 0 || stalls != 0) begin n_err++; $display("FAIL b2b_throughput got gaps %0d stalls %0d want 0 0", gaps, stalls); end
        n_cmp++;
        if (got != 50) begin n_err++; $display("FAIL b2b_count got %0d want 50", got); end
        tick();
    endtask

    task automatic test_reset_mid();
        int stale, cyc;
        stale = 0; cyc = 0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_dividend = 8'(i * 11 + 5); in_divisor = 8'd3;
            tick();
        end
        in_valid = 1'b0;
        repeat (5) tick();
        n_cmp++;
        if ({out_valid, busy} !== 2'b11) begin n_err++; $display("FAIL mid_before got %b want 11", {out_valid, busy}); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, busy, in_ready} !== 3'b000) begin n_err++; $display("FAIL mid_reset got %b want 000", {out_valid, busy, in_ready}); end
        repeat (2) tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid || busy) stale++;
        end
        n_cmp++;
        if (stale != 0) begin n_err++; $display("FAIL mid_stale got %0d want 0", stale); end
        in_valid = 1'b1; in_dividend = 8'd20; in_divisor = 8'd6;
        tick();
        in_valid = 1'b0;
        while (!out_valid && cyc < 20) begin tick(); cyc++; end
        n_cmp++;
        if (head !== {1'b0, 8'd3, 8'd2} || out_valid !== 1'b1) begin n_err++; $display("FAIL mid_20_6 got %b/%h want 1/%h", out_valid, head, {1'b0, 8'd3, 8'd2}); end
        tick();
    endtask

    initial begin
        #1;
        test_reset();
        test_latency();
        test_signed();
        test_div0();
        test_fill();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
